// File: rtl/gpu_pkg.sv
// Shared display geometry and arbiter state encoding for the character pipeline.
package gpu_pkg;

  localparam int COLS       = 40;
  localparam int ROWS       = 25;
  localparam int CELL_PX    = 16;
  localparam int CELL_LINES = 16;
  localparam int H_TOTAL    = 801;
  localparam int PREFETCH   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/scan_addr_gen.sv
// Combinational fetch-slot detector: maps the timing generator's x/y onto
// "fetch this cell now" plus the character cell address, PREFETCH clocks early.
module scan_addr_gen #(
  parameter int ADDR_W     = 10,
  parameter int COLS       = gpu_pkg::COLS,
  parameter int ROWS       = gpu_pkg::ROWS,
  parameter int CELL_PX    = gpu_pkg::CELL_PX,
  parameter int CELL_LINES = gpu_pkg::CELL_LINES,
  parameter int H_TOTAL    = gpu_pkg::H_TOTAL,
  parameter int PREFETCH   = gpu_pkg::PREFETCH
) (
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  output logic              slot_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int          PX_LG = $clog2(CELL_PX);
  localparam int          LN_LG = $clog2(CELL_LINES);
  localparam logic [10:0] PF    = 11'(PREFETCH);
  localparam logic [10:0] HT    = 11'(H_TOTAL);
  localparam logic [10:0] XLIM  = 11'(COLS * CELL_PX);
  localparam logic [10:0] YLIM  = 11'(ROWS * CELL_LINES);

  logic [10:0] xp_raw;
  logic [10:0] xp;
  logic [10:0] line;
  logic        wrap;

  // Look PREFETCH pixels ahead; a lookahead past end of line lands on the next line.
  always_comb begin
    xp_raw = {1'b0, x_i} + PF;
    wrap   = (xp_raw >= HT);
    xp     = wrap ? (xp_raw - HT) : xp_raw;
    line   = wrap ? ({1'b0, y_i} + 11'd1) : {1'b0, y_i};
    slot_o = (xp[PX_LG-1:0] == '0) && (xp < XLIM) && (line < YLIM);
    addr_o = ADDR_W'(line >> LN_LG) * ADDR_W'(COLS) + ADDR_W'(xp >> PX_LG);
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout fetch owns slot cycles outright, the CPU
// gets the port on any other cycle through a three-state IDLE/ISSUE/DATA FSM.
module vram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int COLS       = gpu_pkg::COLS,
  parameter int ROWS       = gpu_pkg::ROWS,
  parameter int CELL_PX    = gpu_pkg::CELL_PX,
  parameter int CELL_LINES = gpu_pkg::CELL_LINES,
  parameter int H_TOTAL    = gpu_pkg::H_TOTAL,
  parameter int PREFETCH   = gpu_pkg::PREFETCH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic [DATA_W-1:0] char_code,
  output logic              char_valid
);

  import gpu_pkg::*;

  arb_state_e        state_q, state_d;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] wdata_hold_q;
  logic [DATA_W-1:0] rdata_q;
  logic              vld_p0, vld_p1;
  logic [DATA_W-1:0] char_p1;
  logic              scan_slot;
  logic [ADDR_W-1:0] scan_addr;
  logic              issue_go;
  logic              cpu_rd_done;

  scan_addr_gen #(
    .ADDR_W    (ADDR_W),
    .COLS      (COLS),
    .ROWS      (ROWS),
    .CELL_PX   (CELL_PX),
    .CELL_LINES(CELL_LINES),
    .H_TOTAL   (H_TOTAL),
    .PREFETCH  (PREFETCH)
  ) u_scan (
    .x_i   (x),
    .y_i   (y),
    .slot_o(scan_slot),
    .addr_o(scan_addr)
  );

  // The CPU only touches the port in ISSUE cycles that scanout does not claim.
  assign issue_go    = (state_q == ISSUE) && !scan_slot;
  assign cpu_rd_done = (state_q == DATA) && !req_we_q;

  // Next-state: ISSUE waits out slot cycles, DATA always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req)    state_d = ISSUE;
      ISSUE:   if (!scan_slot) state_d = DATA;
      DATA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture the CPU request at acceptance so the bus may change afterwards.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && cpu_req) begin
      req_we_q    <= cpu_we;
      req_addr_q  <= cpu_addr;
      req_wdata_q <= cpu_wdata;
    end
  end

  // Port address/data hold their last driven value; read data kept for the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      rdata_q      <= '0;
    end else begin
      addr_hold_q  <= vram_addr;
      wdata_hold_q <= vram_wdata;
      if (cpu_rd_done) rdata_q <= vram_rdata;
    end
  end

  // Scan pipeline: p0 = RAM access in flight, p1 = character code registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      char_p1 <= '0;
    end else begin
      vld_p0 <= scan_slot;
      vld_p1 <= vld_p0;
      if (vld_p0) char_p1 <= vram_rdata;
    end
  end

  assign vram_addr  = scan_slot ? scan_addr : (issue_go ? req_addr_q : addr_hold_q);
  assign vram_we    = issue_go && req_we_q;
  assign vram_wdata = issue_go ? req_wdata_q : wdata_hold_q;
  assign cpu_ack    = (state_q == DATA);
  assign cpu_rdata  = cpu_rd_done ? vram_rdata : rdata_q;
  assign char_code  = char_p1;
  assign char_valid = vld_p1;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency VRAM.
module tb_vram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] x, y;
  logic       cpu_req, cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic [9:0] vram_addr;
  logic       vram_we;
  logic [7:0] vram_wdata;
  logic [7:0] vram_rdata;
  logic [7:0] char_code;
  logic       char_valid;

  logic [7:0] mem [1024];
  logic       preload;
  int         wr_count = 0;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .vram_addr (vram_addr),
    .vram_we   (vram_we),
    .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata),
    .char_code (char_code),
    .char_valid(char_valid)
  );

  function automatic logic [7:0] init_val(int a);
    return 8'(a * 3 + 16);
  endfunction

  // Single-port RAM: registered read of the presented address, write on vram_we.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
    end
    vram_rdata <= mem[vram_addr];
  end

  // Counts RAM write cycles to catch duplicate or stray writes.
  always @(posedge clk) begin
    if (vram_we === 1'b1) wr_count <= wr_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    preload   = 1'b1;
    rst_n     = 1'b0;
    x         = 10'd0;
    y         = 10'd0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 10'd0;
    cpu_wdata = 8'd0;
    repeat (3) tick();
    preload = 1'b0;
    rst_n   = 1'b1;
    settle();
    chk("rst_ack",        cpu_ack,    0);
    chk("rst_rdata",      cpu_rdata,  0);
    chk("rst_vaddr",      vram_addr,  0);
    chk("rst_vwe",        vram_we,    0);
    chk("rst_vwdata",     vram_wdata, 0);
    chk("rst_char_code",  char_code,  0);
    chk("rst_char_valid", char_valid, 0);

    // First fetch of line 0: x=14 looks ahead to pixel 16 -> column 1.
    tick(); x = 10'd14; settle();
    chk("slot14_addr", vram_addr, 1);
    chk("slot14_we",   vram_we,   0);
    tick(); x = 10'd15; settle();
    chk("x15_cvalid",  char_valid, 0);
    tick(); x = 10'd16; settle();
    chk("x16_cvalid",  char_valid, 1);
    chk("x16_ccode",   char_code,  init_val(1));
    tick(); x = 10'd17; settle();
    chk("x17_cvalid",  char_valid, 0);

    // Geometry corners.
    tick(); x = 10'd799; y = 10'd15; settle();
    chk("wrap_row1_addr", vram_addr, 40);
    tick(); x = 10'd622; y = 10'd0; settle();
    chk("col39_addr", vram_addr, 39);
    tick(); x = 10'd638; settle();
    chk("col40_noslot_hold", vram_addr, 39);
    tick(); x = 10'd799; y = 10'd399; settle();
    chk("lastline_noslot_hold", vram_addr, 39);

    // CPU write then back-to-back read on an idle display.
    tick(); x = 10'd100; y = 10'd450;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd5; cpu_wdata = 8'h41; settle();
    chk("wr_idle_ack", cpu_ack, 0);
    chk("wr_idle_we",  vram_we, 0);
    tick();
    chk("wr_issue_we",    vram_we,    1);
    chk("wr_issue_addr",  vram_addr,  5);
    chk("wr_issue_wdata", vram_wdata, 8'h41);
    chk("wr_issue_ack",   cpu_ack,    0);
    tick();
    chk("wr_data_ack", cpu_ack, 1);
    chk("wr_data_we",  vram_we, 0);
    cpu_we = 1'b0;
    tick();
    chk("b2b_idle_ack", cpu_ack, 0);
    chk("b2b_idle_we",  vram_we, 0);
    chk("b2b_wr_count", wr_count, 1);
    tick();
    chk("rd_issue_addr", vram_addr, 5);
    chk("rd_issue_we",   vram_we,   0);
    tick();
    chk("rd_data_ack",   cpu_ack,   1);
    chk("rd_data_rdata", cpu_rdata, 8'h41);
    cpu_req = 1'b0;
    tick();
    chk("rd_after_ack",   cpu_ack,   0);
    chk("rd_after_rdata", cpu_rdata, 8'h41);

    // ISSUE lands on the x=14 slot: scan wins, CPU write goes one cycle later.
    x = 10'd13; y = 10'd0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd7; cpu_wdata = 8'hEE; settle();
    chk("col_idle_we", vram_we, 0);
    tick(); x = 10'd14; settle();
    chk("col_slot_addr", vram_addr, 1);
    chk("col_slot_we",   vram_we,   0);
    chk("col_slot_ack",  cpu_ack,   0);
    tick(); x = 10'd15; settle();
    chk("col_issue_we",    vram_we,    1);
    chk("col_issue_addr",  vram_addr,  7);
    chk("col_issue_wdata", vram_wdata, 8'hEE);
    chk("col_issue_ack",   cpu_ack,    0);
    tick(); x = 10'd16; settle();
    chk("col_ack",    cpu_ack,    1);
    chk("col_cvalid", char_valid, 1);
    chk("col_ccode",  char_code,  init_val(1));
    cpu_req = 1'b0;
    tick(); x = 10'd17; settle();
    chk("col_after_ack", cpu_ack,  0);
    chk("col_wr_count",  wr_count, 2);

    // Reset pulsed while a write sits stalled in ISSUE.
    x = 10'd13;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd3; cpu_wdata = 8'h55; settle();
    tick(); x = 10'd14; settle();
    chk("rstmid_issue_we", vram_we, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_low_we",  vram_we, 0);
    chk("rstmid_low_ack", cpu_ack, 0);
    tick(); x = 10'd15; settle();
    chk("rstmid_hold_we",  vram_we, 0);
    chk("rstmid_hold_ack", cpu_ack, 0);
    cpu_req = 1'b0;
    rst_n   = 1'b1;
    tick(); x = 10'd100; y = 10'd450; settle();
    chk("rstmid_post_ack",   cpu_ack,  0);
    chk("rstmid_post_we",    vram_we,  0);
    chk("rstmid_wr_count",   wr_count, 2);

    // Normal read after reset recovery: addr 3 still holds its initial value.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd3; settle();
    tick();
    chk("post_issue_addr", vram_addr, 3);
    chk("post_issue_we",   vram_we,   0);
    tick();
    chk("post_ack",   cpu_ack,   1);
    chk("post_rdata", cpu_rdata, init_val(3));
    cpu_req = 1'b0;
    tick();
    chk("post_after_ack", cpu_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
